// File: rtl/mips_alu_mc_if.sv
// Request/response bundle between the control unit and the multi-cycle ALU.
// The slave side is the ALU; the master side is the control unit or a testbench.
interface mips_alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       op_i;
  logic [WIDTH-1:0] src_a_i;
  logic [WIDTH-1:0] src_b_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_lo_o;
  logic [WIDTH-1:0] result_hi_o;
  logic             zero_o;
  logic             div0_o;

  modport slave (
    input  valid_i, op_i, src_a_i, src_b_i, ready_i,
    output ready_o, valid_o, result_lo_o, result_hi_o, zero_o, div0_o
  );

  modport master (
    output valid_i, op_i, src_a_i, src_b_i, ready_i,
    input  ready_o, valid_o, result_lo_o, result_hi_o, zero_o, div0_o
  );
endinterface

// File: rtl/mips_alu_mc.sv
// Multi-cycle MIPS ALU: 1-cycle ALU ops, WIDTH+1-cycle MULTU/DIVU (shift-add / restoring).
// Accepts only in IDLE; the result is held in DONE until ready_i, so a stalled consumer loses nothing.
module mips_alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  mips_alu_mc_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_mul;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_res_lo;
  logic [WIDTH-1:0] r_res_hi;
  logic             r_zero;
  logic             r_div0;

  logic             w_accept;
  logic [WIDTH-1:0] w_alu_lo;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  assign w_accept = bus.valid_i && (r_state == S_IDLE);

  always_comb begin
    w_alu_lo = '0;
    case (bus.op_i)
      OP_ADD:  w_alu_lo = bus.src_a_i + bus.src_b_i;
      OP_SUB:  w_alu_lo = bus.src_a_i - bus.src_b_i;
      OP_AND:  w_alu_lo = bus.src_a_i & bus.src_b_i;
      OP_OR:   w_alu_lo = bus.src_a_i | bus.src_b_i;
      OP_SLT:  w_alu_lo = {{(WIDTH-1){1'b0}}, $signed(bus.src_a_i) < $signed(bus.src_b_i)};
      OP_SLTU: w_alu_lo = {{(WIDTH-1){1'b0}}, bus.src_a_i < bus.src_b_i};
      default: w_alu_lo = '0;
    endcase
  end

  // Multiply: multiplier sits in lo and is consumed LSB-first as partial sums shift in from hi.
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};

  // Divide: the trial subtract needs one extra bit since the shifted remainder can reach 2*divisor-1.
  assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_ok    = !w_div_diff[WIDTH];
  assign w_div_hi    = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
  assign w_div_lo    = {r_acc_lo[WIDTH-2:0], w_div_ok};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_mul <= 1'b0;
      r_opnd   <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_zero   <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_zero <= (bus.src_a_i == bus.src_b_i);
            r_div0 <= 1'b0;
            case (bus.op_i)
              OP_MULTU: begin
                r_is_mul <= 1'b1;
                r_opnd   <= bus.src_a_i;
                r_acc_hi <= '0;
                r_acc_lo <= bus.src_b_i;
                r_cnt    <= CNT_W'(WIDTH);
                r_state  <= S_BUSY;
              end
              OP_DIVU: begin
                if (bus.src_b_i == '0) begin
                  r_res_lo <= '1;
                  r_res_hi <= bus.src_a_i;
                  r_div0   <= 1'b1;
                  r_state  <= S_DONE;
                end else begin
                  r_is_mul <= 1'b0;
                  r_opnd   <= bus.src_b_i;
                  r_acc_hi <= '0;
                  r_acc_lo <= bus.src_a_i;
                  r_cnt    <= CNT_W'(WIDTH);
                  r_state  <= S_BUSY;
                end
              end
              default: begin
                r_res_lo <= w_alu_lo;
                r_res_hi <= '0;
                r_state  <= S_DONE;
              end
            endcase
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_res_lo <= r_acc_lo;
            r_res_hi <= r_acc_hi;
            r_state  <= S_DONE;
          end else begin
            r_cnt    <= r_cnt - 1'b1;
            r_acc_hi <= r_is_mul ? w_mul_hi : w_div_hi;
            r_acc_lo <= r_is_mul ? w_mul_lo : w_div_lo;
          end
        end
        S_DONE: begin
          if (bus.ready_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o     = (r_state == S_IDLE);
  assign bus.valid_o     = (r_state == S_DONE);
  assign bus.result_lo_o = r_res_lo;
  assign bus.result_hi_o = r_res_hi;
  assign bus.zero_o      = r_zero;
  assign bus.div0_o      = r_div0;
endmodule

// File: doc/mips_alu_mc.md
Name: mips_alu_mc

Overview:
Parametrised multi-cycle ALU for the MIPS datapath. It is the successor to the single-cycle combinational ALU.
- Keeps the ADD/SUB/AND/OR/SLT codes and the branch-equality zero flag.
- Adds SLTU, an iterative unsigned multiplier (MULTU) and an iterative unsigned divider (DIVU) with HI/LO results.
- Sits between the register-file read stage and the writeback/HI-LO registers, and talks to the control unit through a valid/ready handshake on both sides.

Parameters:
WIDTH, 32, operand and result width in bits (>= 4).
CNT_W, $clog2(WIDTH+1), width of the internal iteration counter (derived, not overridden).

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
valid_i  in  1  operation request
ready_o  out  1  block can accept a request
op_i  in  4  operation code
src_a_i  in  WIDTH  operand A (rs)
src_b_i  in  WIDTH  operand B (rt/imm)
valid_o  out  1  result valid
ready_i  in  1  consumer accepts result
result_lo_o  out  WIDTH  ALU result / product low / quotient
result_hi_o  out  WIDTH  product high / remainder (0 for non-MULTU/DIVU)
zero_o  out  1  registered (src_a_i == src_b_i) of the accepted request
div0_o  out  1  DIVU with src_b_i == 0

Behaviour:
- Op codes:
  - 0010 ADD
  - 0110 SUB
  - 0000 AND
  - 0001 OR
  - 0111 SLT (signed)
  - 0011 SLTU (unsigned)
  - 1000 MULTU
  - 1001 DIVU
  - any other code: result_lo = result_hi = 0, zero_o still computed.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH, no overflow flag.
  - SLT/SLTU return 1 or 0 in bit 0, upper bits 0.
- FSM states: IDLE, BUSY, DONE.
- Reset values:
  - state = IDLE
  - ready_o = 1, valid_o = 0
  - result_lo_o = result_hi_o = 0
  - zero_o = 0, div0_o = 0
- ready_o = 1 only in IDLE. A request is accepted on a cycle where valid_i && ready_o. Operands and op are captured at acceptance; later input changes are ignored.
- IDLE -> DONE on a single-cycle op. Outputs are registered, so valid_o rises the cycle after acceptance (latency 1).
- IDLE -> BUSY on MULTU/DIVU. The counter loads WIDTH.
- BUSY, one iteration per cycle:
  - MULTU: shift-add on a {hi, lo} 2*WIDTH accumulator.
  - DIVU: restoring; remainder in hi, quotient in lo.
  - The counter decrements. BUSY -> DONE when the counter reaches 0, so valid_o asserts exactly WIDTH+1 cycles after acceptance.
- DIVU with src_b == 0 skips BUSY: IDLE -> DONE at latency 1, with result_lo = all ones, result_hi = src_a, div0_o = 1. div0_o is 0 for all other ops.
- DONE: valid_o = 1 and all outputs hold stable until valid_o && ready_i. Then DONE -> IDLE and valid_o drops the next cycle. No new request is accepted in the handshake cycle (ready_o = 0 in DONE), so back-to-back single-cycle ops issue every 2 cycles minimum.
- ready_i low in DONE is held indefinitely with no loss of data.
- zero_o is captured at acceptance for every op and held with the result.
- rst_ni asserted in any state (including mid-BUSY) immediately returns all outputs and the FSM to reset values. The partial result is discarded and no valid_o is produced for the aborted op.

Test Plan:
1. WIDTH=32, ADD 0xFFFFFFFF + 0x00000001 -> valid_o 1 cycle after accept; result_lo = 0x00000000, result_hi = 0, zero_o = 0.
2. SLT a = 0xFFFFFFFE (-2), b = 0x00000003 -> result_lo = 1; SLTU with the same operands -> result_lo = 0. SUB 5 - 5 -> result_lo = 0, zero_o = 1.
3. MULTU 0xFFFFFFFF * 0xFFFFFFFF -> valid_o exactly 33 cycles after accept; hi = 0xFFFFFFFE, lo = 0x00000001. ready_o = 0 throughout.
4. DIVU 100 / 7 -> lo = 14, hi = 2 after 33 cycles. DIVU 100 / 0 -> latency 1, lo = 0xFFFFFFFF, hi = 100, div0_o = 1.
5. Hold ready_i = 0 for 10 cycles in DONE -> outputs stable, valid_o high. Raise ready_i -> valid_o low and ready_o high on the next cycle. Change src_a_i while BUSY -> result unaffected.
6. Assert rst_ni low at cycle 10 of a MULTU -> all outputs zero and ready_o = 1 immediately. Release, then issue ADD 2 + 3 -> result_lo = 5 with no stale valid_o.
